cosim_vector_sequencer: RTL and testbench

//   Sequences a 128-bit combinational gate DUT (buf/not/and fanout cosim specs)

---
 rtl/cosim_vector_sequencer.sv | 133 +++++++++++++
 tb/tb_cosim_vector_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_vector_sequencer.sv
// Clocked sequencer for a combinational gate DUT: fetches stimulus/expected
// pairs, holds the stimulus for SETTLE cycles, compares the DUT response and
// accumulates per-run pass/fail statistics.
module cosim_vector_sequencer #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_data,
  input  logic [WIDTH-1:0] exp_data,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic             res_pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] exp_reg;
  logic [SET_W-1:0] settle_cnt;

  // Sequencer FSM; outputs are registered and updated on each state change so
  // they line up with the state they describe. The DUT response is captured on
  // the last APPLY edge, after dut_in has been stable for SETTLE cycles, and is
  // presented as res_valid/res_pass during CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      n_reg            <= '0;
      idx              <= '0;
      exp_reg          <= '0;
      settle_cnt       <= '0;
      dut_in           <= '0;
      vec_ready        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      res_valid        <= 1'b0;
      res_pass         <= 1'b0;
      mismatch_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx              <= '0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            if (num_vectors != '0) begin
              n_reg     <= num_vectors;
              busy      <= 1'b1;
              vec_ready <= 1'b1;
              state     <= S_FETCH;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (vec_valid) begin
            dut_in     <= vec_data;
            exp_reg    <= exp_data;
            settle_cnt <= SET_W'(SETTLE - 1);
            vec_ready  <= 1'b0;
            state      <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (settle_cnt == '0) begin
            res_valid <= 1'b1;
            res_pass  <= (dut_out == exp_reg);
            state     <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        S_CHECK: begin
          if (!res_pass) begin
            if (mismatch_count != '1) begin
              mismatch_count <= mismatch_count + CNT_W'(1);
            end
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= idx;
            end
          end
          if (idx == n_reg - CNT_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx       <= idx + CNT_W'(1);
            vec_ready <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cosim_vector_sequencer.sv
// Bench for cosim_vector_sequencer driving a buffer DUT (dut_out = dut_in).
module tb_cosim_vector_sequencer;

  localparam int unsigned WIDTH  = 128;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             vec_valid = 1'b0;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_data = '0;
  logic [WIDTH-1:0] exp_data = '0;
  logic [WIDTH-1:0] dut_in;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             res_valid;
  logic             res_pass;
  logic [CNT_W-1:0] mismatch_count;
  logic             first_fail_valid;
  logic [CNT_W-1:0] first_fail_idx;

  cosim_vector_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .exp_data(exp_data), .dut_in(dut_in), .dut_out(dut_out), .busy(busy),
    .done(done), .res_valid(res_valid), .res_pass(res_pass),
    .mismatch_count(mismatch_count), .first_fail_valid(first_fail_valid),
    .first_fail_idx(first_fail_idx)
  );

  // Buffer gate under test
  assign dut_out = dut_in;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_q[$];
  int res_cycles[$];
  int done_cnt   = 0;
  int done_cycle = 0;
  bit ready_seen = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every result pulse, tracks done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (vec_ready) ready_seen = 1'b1;
      if (res_valid) begin
        res_cycles.push_back(cyc);
        if (exp_q.size() != 0) begin
          check("res_pass", 128'(res_pass), 128'(exp_q.pop_front()));
        end else begin
          n_checks++;
          $display("FAIL sb_underflow: res_valid with no expected entry at cycle %0d", cyc);
        end
      end
      if (done) begin
        done_cnt++;
        done_cycle = cyc;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge
  task automatic send(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] e);
    bit ok = 1'b0;
    vec_valid = 1'b1;
    vec_data  = v;
    exp_data  = e;
    exp_q.push_back(v == e);
    for (int c = 0; c < 50; c++) begin
      if (vec_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vec_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: vec_ready never seen for %0h", v);
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start       = 1'b1;
    num_vectors = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    for (int c = 0; c < 40 && done_cnt == prev; c++) @(negedge clk);
    check("done_seen", 128'(done_cnt), 128'(prev + 1));
  endtask

  logic [WIDTH-1:0] v4 [4];
  int d0;
  int r0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_vec_ready", 128'(vec_ready), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_done", 128'(done), 0);
    check("rst_res_valid", 128'(res_valid), 0);
    check("rst_res_pass", 128'(res_pass), 0);
    check("rst_mismatch", 128'(mismatch_count), 0);
    check("rst_ff_valid", 128'(first_fail_valid), 0);
    check("rst_ff_idx", 128'(first_fail_idx), 0);
    check("rst_dut_in", dut_in, 0);

    // Three matching vectors, continuously valid source
    res_cycles.delete();
    d0 = done_cnt;
    do_start(16'd3);
    check("run1_busy", 128'(busy), 1);
    send(128'd1, 128'd1);
    send(128'd2, 128'd2);
    send(128'd3, 128'd3);
    wait_done(d0);
    repeat (3) @(negedge clk);
    check("run1_done_once", 128'(done_cnt), 128'(d0 + 1));
    check("run1_n_res", 128'(res_cycles.size()), 3);
    if (res_cycles.size() == 3) begin
      check("run1_gap01", 128'(res_cycles[1] - res_cycles[0]), 4);
      check("run1_gap12", 128'(res_cycles[2] - res_cycles[1]), 4);
      check("run1_done_lat", 128'(done_cycle - res_cycles[2]), 1);
    end
    check("run1_mismatch", 128'(mismatch_count), 0);
    check("run1_ff_valid", 128'(first_fail_valid), 0);
    check("run1_dut_in_hold", dut_in, 128'd3);
    check("run1_busy_after", 128'(busy), 0);
    check("run1_sb_empty", 128'(exp_q.size()), 0);

    // Four vectors, expected[1] (top bit) and expected[3] (bit 0) corrupted
    v4[0] = {4{32'hDEADBEEF}};
    v4[1] = {4{32'h0F0F_1234}};
    v4[2] = '1;
    v4[3] = {2{64'h0123_4567_89AB_CDEF}};
    d0 = done_cnt;
    do_start(16'd4);
    send(v4[0], v4[0]);
    send(v4[1], v4[1] ^ {1'b1, 127'd0});
    send(v4[2], v4[2]);
    send(v4[3], v4[3] ^ 128'd1);
    wait_done(d0);
    @(negedge clk);
    check("run2_mismatch", 128'(mismatch_count), 2);
    check("run2_ff_valid", 128'(first_fail_valid), 1);
    check("run2_ff_idx", 128'(first_fail_idx), 1);
    check("run2_sb_empty", 128'(exp_q.size()), 0);

    // Zero-length run clears statistics and never raises vec_ready
    ready_seen = 1'b0;
    d0 = done_cnt;
    do_start(16'd0);
    check("zero_done_next", 128'(done), 1);
    check("zero_mismatch", 128'(mismatch_count), 0);
    check("zero_ff_valid", 128'(first_fail_valid), 0);
    check("zero_ff_idx", 128'(first_fail_idx), 0);
    repeat (4) @(negedge clk);
    check("zero_no_ready", 128'(ready_seen), 0);
    check("zero_done_once", 128'(done_cnt), 128'(d0 + 1));

    // Source stalls in FETCH; start while busy is ignored
    d0 = done_cnt;
    do_start(16'd2);
    r0 = res_cycles.size();
    repeat (10) @(negedge clk);
    do_start(16'd7);
    repeat (2) @(negedge clk);
    check("stall_no_res", 128'(res_cycles.size()), 128'(r0));
    check("stall_ready", 128'(vec_ready), 1);
    check("stall_busy", 128'(busy), 1);
    send({4{32'hAAAA_AAAA}}, {4{32'hAAAA_AAAA}});
    send({4{32'h5555_5555}}, {4{32'h5555_5554}});
    wait_done(d0);
    repeat (3) @(negedge clk);
    check("stall_n_res", 128'(res_cycles.size()), 128'(r0 + 2));
    check("stall_busy_after", 128'(busy), 0);
    check("stall_mismatch", 128'(mismatch_count), 1);
    check("stall_ff_idx", 128'(first_fail_idx), 1);

    // Reset during APPLY of vector 2 of 5
    d0 = done_cnt;
    do_start(16'd5);
    send(128'h11, 128'h11);
    send(128'h22, 128'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy", 128'(busy), 0);
    check("abort_ready", 128'(vec_ready), 0);
    check("abort_dut_in", dut_in, 0);
    repeat (5) @(negedge clk);
    check("abort_no_done", 128'(done_cnt), 128'(d0));
    check("abort_idle_ready", 128'(vec_ready), 0);

    // Clean single-vector run after abort
    d0 = done_cnt;
    do_start(16'd1);
    send(128'hCAFE, 128'hCAFE);
    wait_done(d0);
    @(negedge clk);
    check("post_mismatch", 128'(mismatch_count), 0);
    check("post_ff_valid", 128'(first_fail_valid), 0);
    check("post_dut_in", dut_in, 128'hCAFE);
    check("post_sb_empty", 128'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
